// File: rtl/mmu_dcache_req_arb_if.sv
// Request/E2 bundle between E1 data-cache requesters and the dcache request arbiter.
//   slave  : arbiter side (takes E1 requests and stall, drives grant and E2 stage)
//   master : requester/pipeline side
interface mmu_dcache_req_arb_if #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned VADDR_W = 41,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         e1_req_i;
  logic [NUM_CH*VADDR_W-1:0] e1_vaddr_i;
  logic [NUM_CH-1:0]         e1_glob_i;
  logic [NUM_CH*4-1:0]       e1_size_i;
  logic [NUM_CH-1:0]         e1_non_trap_i;
  logic [NUM_CH*6-1:0]       e1_opc_i;
  logic [NUM_CH-1:0]         e1_grant_o;
  logic                      dcache_e3_stall_i;
  logic                      e2_valid_o;
  logic [CH_W-1:0]           e2_ch_o;
  logic [VADDR_W-1:0]        e2_vaddr_o;
  logic [5:0]                e2_opc_o;
  logic [3:0]                e2_size_o;
  logic                      e2_glob_o;
  logic                      e2_stall_o;
  logic                      e2_trap_dmisalign_o;
  logic                      e2_trap_dsyserror_o;
  logic                      e2_non_trapping_id_cancel_o;
  logic [CNT_W-1:0]          misalign_cnt_o;

  modport slave (
    input  e1_req_i, e1_vaddr_i, e1_glob_i, e1_size_i, e1_non_trap_i, e1_opc_i,
           dcache_e3_stall_i,
    output e1_grant_o, e2_valid_o, e2_ch_o, e2_vaddr_o, e2_opc_o, e2_size_o, e2_glob_o,
           e2_stall_o, e2_trap_dmisalign_o, e2_trap_dsyserror_o,
           e2_non_trapping_id_cancel_o, misalign_cnt_o
  );

  modport master (
    output e1_req_i, e1_vaddr_i, e1_glob_i, e1_size_i, e1_non_trap_i, e1_opc_i,
           dcache_e3_stall_i,
    input  e1_grant_o, e2_valid_o, e2_ch_o, e2_vaddr_o, e2_opc_o, e2_size_o, e2_glob_o,
           e2_stall_o, e2_trap_dmisalign_o, e2_trap_dsyserror_o,
           e2_non_trapping_id_cancel_o, misalign_cnt_o
  );
endinterface

// File: rtl/mmu_dcache_req_arb.sv
// Round-robin arbiter of NUM_CH E1 dcache requesters into a single E2 stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mmu_dcache_req_arb_if (E1 requests/fields, one-hot
//                grant, dcache E3 stall, registered E2 access, traps, misalign counter)
module mmu_dcache_req_arb #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned VADDR_W = 41,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  mmu_dcache_req_arb_if.slave bus
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = CH_W + 1;

  localparam logic [5:0] OPC_LOAD    = 6'b000001;
  localparam logic [5:0] OPC_STORE   = 6'b000010;
  localparam logic [5:0] OPC_LDC     = 6'b000011;
  localparam logic [5:0] OPC_FDA     = 6'b000111;
  localparam logic [5:0] OPC_CWS     = 6'b001111;
  localparam logic [5:0] OPC_DZEROL  = 6'b100000;
  localparam logic [5:0] OPC_DINVALL = 6'b011000;
  localparam logic [5:0] OPC_DTOUCHL = 6'b011100;
  localparam logic [5:0] OPC_DINVAL  = 6'b111000;
  localparam logic [5:0] OPC_WPURGE  = 6'b001000;

  logic [CH_W-1:0]    ptr_q;
  logic [CH_W-1:0]    win_c;
  logic [SUM_W-1:0]   idx_c;
  logic               any_c;
  logic [NUM_CH-1:0]  grant_c;

  logic [VADDR_W-1:0] w_vaddr_c;
  logic [5:0]         w_opc_c;
  logic [3:0]         w_size_c;
  logic               w_glob_c;
  logic               w_nt_c;

  logic               line_op_c, mem_op_c, size_ok_c, sys_c, mis_c;

  logic               e2_valid_q;
  logic [CH_W-1:0]    e2_ch_q;
  logic [VADDR_W-1:0] e2_vaddr_q;
  logic [5:0]         e2_opc_q;
  logic [3:0]         e2_size_q;
  logic               e2_glob_q;
  logic               dmis_q, sys_q, cancel_q;
  logic [CNT_W-1:0]   cnt_q;

  // Rotating-priority search: first requester at or after ptr_q, wrapping.
  always_comb begin
    grant_c = '0;
    win_c   = '0;
    any_c   = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx_c = {1'b0, ptr_q} + SUM_W'(i);
      if (idx_c >= SUM_W'(NUM_CH)) idx_c = idx_c - SUM_W'(NUM_CH);
      if (!any_c && bus.e1_req_i[idx_c[CH_W-1:0]]) begin
        any_c = 1'b1;
        win_c = idx_c[CH_W-1:0];
      end
    end
    if (!rst_n || bus.dcache_e3_stall_i) any_c = 1'b0;
    if (any_c) grant_c[win_c] = 1'b1;
  end

  // Winner field mux.
  always_comb begin
    w_vaddr_c = '0;
    w_opc_c   = '0;
    w_size_c  = '0;
    w_glob_c  = 1'b0;
    w_nt_c    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_c == CH_W'(i)) begin
        w_vaddr_c = bus.e1_vaddr_i[i*VADDR_W +: VADDR_W];
        w_opc_c   = bus.e1_opc_i[i*6 +: 6];
        w_size_c  = bus.e1_size_i[i*4 +: 4];
        w_glob_c  = bus.e1_glob_i[i];
        w_nt_c    = bus.e1_non_trap_i[i];
      end
    end
  end

  // Trap classification; line ops bypass size and alignment checks entirely.
  always_comb begin
    line_op_c = w_opc_c inside {OPC_DZEROL, OPC_DINVALL, OPC_DTOUCHL, OPC_DINVAL, OPC_WPURGE};
    mem_op_c  = w_opc_c inside {OPC_LOAD, OPC_STORE, OPC_LDC, OPC_FDA, OPC_CWS};
    size_ok_c = w_size_c inside {4'd1, 4'd2, 4'd4, 4'd8};
    sys_c     = !line_op_c && (!mem_op_c || !size_ok_c);
    mis_c     = mem_op_c && size_ok_c && ((w_vaddr_c[3:0] & (w_size_c - 4'd1)) != 4'd0);
  end

  // E2 stage, round-robin pointer and misalignment counter; all frozen by the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      e2_valid_q <= 1'b0;
      e2_ch_q    <= '0;
      e2_vaddr_q <= '0;
      e2_opc_q   <= '0;
      e2_size_q  <= '0;
      e2_glob_q  <= 1'b0;
      dmis_q     <= 1'b0;
      sys_q      <= 1'b0;
      cancel_q   <= 1'b0;
      cnt_q      <= '0;
    end else if (!bus.dcache_e3_stall_i) begin
      e2_valid_q <= any_c;
      if (any_c) begin
        ptr_q      <= (win_c == CH_W'(NUM_CH - 1)) ? '0 : win_c + CH_W'(1);
        e2_ch_q    <= win_c;
        e2_vaddr_q <= w_vaddr_c;
        e2_opc_q   <= w_opc_c;
        e2_size_q  <= w_size_c;
        e2_glob_q  <= w_glob_c;
        sys_q      <= sys_c;
        dmis_q     <= mis_c && !w_nt_c;
        cancel_q   <= mis_c && w_nt_c;
        if (mis_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        sys_q    <= 1'b0;
        dmis_q   <= 1'b0;
        cancel_q <= 1'b0;
      end
    end
  end

  assign bus.e1_grant_o                  = grant_c;
  assign bus.e2_valid_o                  = e2_valid_q;
  assign bus.e2_ch_o                     = e2_ch_q;
  assign bus.e2_vaddr_o                  = e2_vaddr_q;
  assign bus.e2_opc_o                    = e2_opc_q;
  assign bus.e2_size_o                   = e2_size_q;
  assign bus.e2_glob_o                   = e2_glob_q;
  assign bus.e2_stall_o                  = e2_valid_q & bus.dcache_e3_stall_i;
  assign bus.e2_trap_dmisalign_o         = dmis_q;
  assign bus.e2_trap_dsyserror_o         = sys_q;
  assign bus.e2_non_trapping_id_cancel_o = cancel_q;
  assign bus.misalign_cnt_o              = cnt_q;
endmodule

// File: tb/tb_mmu_dcache_req_arb.sv
module tb_mmu_dcache_req_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mmu_dcache_req_arb_if #(.NUM_CH(2), .VADDR_W(41), .CNT_W(16)) bus ();
  mmu_dcache_req_arb_if #(.NUM_CH(1), .VADDR_W(41), .CNT_W(2))  sbus ();

  mmu_dcache_req_arb #(.NUM_CH(2), .VADDR_W(41), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mmu_dcache_req_arb #(.NUM_CH(1), .VADDR_W(41), .CNT_W(2)) sdut (
    .clk(clk), .rst_n(rst_n), .bus(sbus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 2-channel instance ----------------
  int          m_ptr = 0;
  int          m_win;
  logic        m_valid = 1'b0;
  int          m_ch = 0;
  logic [40:0] m_vaddr = '0;
  logic [5:0]  m_opc = '0;
  logic [3:0]  m_size = '0;
  logic        m_glob = 1'b0;
  logic        m_dmis = 1'b0, m_sys = 1'b0, m_can = 1'b0;
  int          m_cnt = 0;
  logic [40:0] s_vaddr;
  logic [5:0]  s_opc;
  logic [3:0]  s_size;
  logic        s_glob, s_nt;
  logic [1:0]  s_cls;
  logic [1:0]  exp_grant;

  function automatic int pick(input int ptr, input logic [1:0] req, input logic stall,
                              input logic rn);
    if (!rn || stall) return -1;
    for (int i = 0; i < 2; i++) begin
      if (req[(ptr + i) % 2]) return (ptr + i) % 2;
    end
    return -1;
  endfunction

  // Returns {dsyserror, misaligned}.
  function automatic logic [1:0] classify(input logic [5:0] opc, input logic [3:0] size,
                                          input logic [40:0] va);
    case (opc)
      6'b100000, 6'b011000, 6'b011100, 6'b111000, 6'b001000: return 2'b00;
      6'b000001, 6'b000010, 6'b000011, 6'b000111, 6'b001111: begin
        if (size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8)
          return {1'b0, (va % {37'd0, size}) != 41'd0};
        return 2'b10;
      end
      default: return 2'b10;
    endcase
  endfunction

  always_comb begin
    m_win   = pick(m_ptr, bus.e1_req_i, bus.dcache_e3_stall_i, rst_n);
    s_vaddr = (m_win == 1) ? bus.e1_vaddr_i[81:41] : bus.e1_vaddr_i[40:0];
    s_opc   = (m_win == 1) ? bus.e1_opc_i[11:6]    : bus.e1_opc_i[5:0];
    s_size  = (m_win == 1) ? bus.e1_size_i[7:4]    : bus.e1_size_i[3:0];
    s_glob  = (m_win == 1) ? bus.e1_glob_i[1]      : bus.e1_glob_i[0];
    s_nt    = (m_win == 1) ? bus.e1_non_trap_i[1]  : bus.e1_non_trap_i[0];
    s_cls   = classify(s_opc, s_size, s_vaddr);
    exp_grant = (m_win == 0) ? 2'b01 : (m_win == 1) ? 2'b10 : 2'b00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_valid <= 1'b0; m_dmis <= 1'b0; m_sys <= 1'b0; m_can <= 1'b0; m_cnt <= 0;
    end else if (!bus.dcache_e3_stall_i) begin
      if (m_win >= 0) begin
        m_valid <= 1'b1;
        m_ch    <= m_win;
        m_ptr   <= (m_win + 1) % 2;
        m_vaddr <= s_vaddr;
        m_opc   <= s_opc;
        m_size  <= s_size;
        m_glob  <= s_glob;
        m_sys   <= s_cls[1];
        m_dmis  <= s_cls[0] & ~s_nt;
        m_can   <= s_cls[0] & s_nt;
        if (s_cls[0] && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end else begin
        m_valid <= 1'b0; m_dmis <= 1'b0; m_sys <= 1'b0; m_can <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("grant",    64'(bus.e1_grant_o), 64'(exp_grant));
    chk("e2_valid", 64'(bus.e2_valid_o), 64'(m_valid));
    chk("e2_stall", 64'(bus.e2_stall_o), 64'(m_valid & bus.dcache_e3_stall_i));
    chk("dmisalign", 64'(bus.e2_trap_dmisalign_o), 64'(m_dmis));
    chk("dsyserror", 64'(bus.e2_trap_dsyserror_o), 64'(m_sys));
    chk("cancel",   64'(bus.e2_non_trapping_id_cancel_o), 64'(m_can));
    chk("cnt",      64'(bus.misalign_cnt_o), 64'(m_cnt));
    if (m_valid) begin
      chk("e2_ch",    64'(bus.e2_ch_o), 64'(m_ch));
      chk("e2_vaddr", 64'(bus.e2_vaddr_o), 64'(m_vaddr));
      chk("e2_opc",   64'(bus.e2_opc_o), 64'(m_opc));
      chk("e2_size",  64'(bus.e2_size_o), 64'(m_size));
      chk("e2_glob",  64'(bus.e2_glob_o), 64'(m_glob));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int c, input logic [5:0] opc, input logic [3:0] size,
                        input logic [40:0] va, input logic nt, input logic glob);
    if (c == 0) begin
      bus.e1_opc_i[5:0] = opc; bus.e1_size_i[3:0] = size; bus.e1_vaddr_i[40:0] = va;
      bus.e1_non_trap_i[0] = nt; bus.e1_glob_i[0] = glob;
    end else begin
      bus.e1_opc_i[11:6] = opc; bus.e1_size_i[7:4] = size; bus.e1_vaddr_i[81:41] = va;
      bus.e1_non_trap_i[1] = nt; bus.e1_glob_i[1] = glob;
    end
  endtask

  logic [5:0] opc_tab [12];

  initial begin
    opc_tab = '{6'b000001, 6'b000010, 6'b000011, 6'b000111, 6'b001111, 6'b100000,
                6'b011000, 6'b011100, 6'b111000, 6'b001000, 6'b010101, 6'b000000};
    bus.e1_req_i = '0; bus.e1_vaddr_i = '0; bus.e1_glob_i = '0; bus.e1_size_i = '0;
    bus.e1_non_trap_i = '0; bus.e1_opc_i = '0; bus.dcache_e3_stall_i = 1'b0;
    sbus.e1_req_i = '0; sbus.e1_vaddr_i = '0; sbus.e1_glob_i = '0; sbus.e1_size_i = '0;
    sbus.e1_non_trap_i = '0; sbus.e1_opc_i = '0; sbus.dcache_e3_stall_i = 1'b0;

    repeat (3) step();
    chk("rst_valid", 64'(bus.e2_valid_o), 64'd0);
    chk("rst_cnt",   64'(bus.misalign_cnt_o), 64'd0);
    chk("rst_grant", 64'(bus.e1_grant_o), 64'd0);
    rst_n = 1'b1;

    // Round robin with both requesting.
    set_ch(0, 6'b000001, 4'd4, 41'h1000, 1'b0, 1'b0);
    set_ch(1, 6'b000001, 4'd4, 41'h2000, 1'b0, 1'b1);
    bus.e1_req_i = 2'b11;
    #1 chk("rr_g0", 64'(bus.e1_grant_o), 64'b01);
    step(); chk("rr_ch0", 64'(bus.e2_ch_o), 64'd0); chk("rr_g1", 64'(bus.e1_grant_o), 64'b10);
    step(); chk("rr_ch1", 64'(bus.e2_ch_o), 64'd1); chk("rr_g2", 64'(bus.e1_grant_o), 64'b01);
    step(); chk("rr_ch2", 64'(bus.e2_ch_o), 64'd0);
    bus.e1_req_i = 2'b00;

    // Misaligned LOAD, trapping then non-trapping.
    set_ch(0, 6'b000001, 4'd8, 41'h1004, 1'b0, 1'b0);
    bus.e1_req_i = 2'b01;
    step();
    chk("mis_dmis", 64'(bus.e2_trap_dmisalign_o), 64'd1);
    chk("mis_cnt1", 64'(bus.misalign_cnt_o), 64'd1);
    bus.e1_non_trap_i[0] = 1'b1;
    step();
    bus.e1_req_i = 2'b00;
    chk("nt_cancel", 64'(bus.e2_non_trapping_id_cancel_o), 64'd1);
    chk("nt_dmis",   64'(bus.e2_trap_dmisalign_o), 64'd0);
    chk("nt_cnt2",   64'(bus.misalign_cnt_o), 64'd2);
    step();
    chk("idle_valid", 64'(bus.e2_valid_o), 64'd0);

    // Syserror / line op cases on ch1.
    set_ch(1, 6'b000010, 4'd3, 41'h1000, 1'b0, 1'b0);
    bus.e1_req_i = 2'b10;
    step();
    chk("st3_sys", 64'(bus.e2_trap_dsyserror_o), 64'd1);
    chk("st3_dmis", 64'(bus.e2_trap_dmisalign_o), 64'd0);
    set_ch(1, 6'b111000, 4'd0, 41'h1003, 1'b0, 1'b0);
    step();
    chk("dinval_sys", 64'(bus.e2_trap_dsyserror_o), 64'd0);
    chk("dinval_dmis", 64'(bus.e2_trap_dmisalign_o), 64'd0);
    set_ch(1, 6'b010101, 4'd4, 41'h1000, 1'b0, 1'b0);
    step();
    chk("badopc_sys", 64'(bus.e2_trap_dsyserror_o), 64'd1);
    bus.e1_req_i = 2'b00;
    step();

    // Stall holding a misaligned LOAD.
    set_ch(0, 6'b000001, 4'd4, 41'h1002, 1'b0, 1'b0);
    set_ch(1, 6'b000001, 4'd4, 41'h2000, 1'b0, 1'b0);
    bus.e1_req_i = 2'b01;
    step();
    chk("stl_cnt3", 64'(bus.misalign_cnt_o), 64'd3);
    bus.dcache_e3_stall_i = 1'b1;
    bus.e1_req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("stl_grant", 64'(bus.e1_grant_o), 64'd0);
      chk("stl_e2stall", 64'(bus.e2_stall_o), 64'd1);
      step();
      chk("stl_vaddr", 64'(bus.e2_vaddr_o), 64'h1002);
      chk("stl_dmis",  64'(bus.e2_trap_dmisalign_o), 64'd1);
      chk("stl_cnt",   64'(bus.misalign_cnt_o), 64'd3);
    end
    bus.dcache_e3_stall_i = 1'b0;
    #1 chk("unstall_grant", 64'(bus.e1_grant_o), 64'b10);
    step(); chk("unstall_ch", 64'(bus.e2_ch_o), 64'd1);

    // Reset asserted mid-stall with E2 valid.
    step();
    bus.dcache_e3_stall_i = 1'b1;
    step();
    chk("pre_rst_valid", 64'(bus.e2_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.e2_valid_o), 64'd0);
    chk("mrst_stall", 64'(bus.e2_stall_o), 64'd0);
    chk("mrst_dmis",  64'(bus.e2_trap_dmisalign_o), 64'd0);
    chk("mrst_cnt",   64'(bus.misalign_cnt_o), 64'd0);
    chk("mrst_grant", 64'(bus.e1_grant_o), 64'd0);
    bus.dcache_e3_stall_i = 1'b0;
    step();
    rst_n = 1'b1;
    #1 chk("post_rst_grant", 64'(bus.e1_grant_o), 64'b01);
    step(); chk("post_rst_ch", 64'(bus.e2_ch_o), 64'd0);
    bus.e1_req_i = 2'b00;
    step();

    // Mixed vectors checked against the model each cycle.
    for (int i = 0; i < 150; i++) begin
      bus.e1_req_i = 2'($urandom_range(0, 3));
      bus.dcache_e3_stall_i = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 2; c++)
        set_ch(c, opc_tab[$urandom_range(0, 11)], 4'($urandom_range(0, 9)),
               41'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    bus.e1_req_i = 2'b00;
    bus.dcache_e3_stall_i = 1'b0;
    step();

    // Single-channel instance with a 2-bit saturating counter.
    sbus.e1_opc_i = 6'b000001; sbus.e1_size_i = 4'd4; sbus.e1_vaddr_i = 41'h3001;
    sbus.e1_req_i = 1'b1;
    #1 chk("s_grant", 64'(sbus.e1_grant_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s_cnt", 64'(sbus.misalign_cnt_o), (i < 3) ? 64'(i + 1) : 64'd3);
      chk("s_ch",  64'(sbus.e2_ch_o), 64'd0);
      chk("s_valid", 64'(sbus.e2_valid_o), 64'd1);
    end
    sbus.dcache_e3_stall_i = 1'b1;
    #1 chk("s_stall_grant", 64'(sbus.e1_grant_o), 64'd0);
    chk("s_e2stall", 64'(sbus.e2_stall_o), 64'd1);
    sbus.e1_req_i = 1'b0;
    sbus.dcache_e3_stall_i = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
